write_pointer_full: RTL and testbench

WRITE_POINTER_FULL -- requirements
Module: write_pointer_full

---
 rtl/write_pointer_full.sv | 65 ++++++
 tb/tb_write_pointer_full.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_pointer_full.sv
// Write-side pointer logic of an async FIFO: binary/Gray write pointer, read-pointer synchronizer, full flag.
// Define FIFO_ALMOST_FULL_EN to build the registered almost-full flag; otherwise write_almost_full is tied low.
module write_pointer_full #(
   parameter int address_size      = 3,
   parameter int almost_full_level = 6
) (
   input  logic                    write_clk,
   input  logic                    write_reset,
   input  logic                    write_clk_en,
   input  logic [address_size:0]   read_pointer_gray,
   output logic [address_size-1:0] write_address,
   output logic [address_size:0]   write_pointer_gray,
   output logic                    write_full,
   output logic                    write_almost_full
);
   localparam int PW = address_size + 1;
   // Full means one lap ahead: top two Gray bits inverted, the rest equal.
   localparam logic [PW-1:0] FULL_MASK = PW'(3) << (address_size - 1);

   logic [PW-1:0] bin, next_bin, next_gray;
   logic [PW-1:0] sync_meta, sync_rptr;
   logic          full_next;

   always_comb begin
      next_bin  = bin + PW'(write_clk_en & ~write_full);
      next_gray = next_bin ^ (next_bin >> 1);
      full_next = (next_gray == (sync_rptr ^ FULL_MASK));
   end

   always_ff @(posedge write_clk or posedge write_reset) begin
      if (write_reset) begin
         bin                <= '0;
         write_pointer_gray <= '0;
         sync_meta          <= '0;
         sync_rptr          <= '0;
         write_full         <= 1'b0;
      end else begin
         sync_meta          <= read_pointer_gray;
         sync_rptr          <= sync_meta;
         bin                <= next_bin;
         write_pointer_gray <= next_gray;
         write_full         <= full_next;
      end
   end

   assign write_address = bin[address_size-1:0];

`ifdef FIFO_ALMOST_FULL_EN
   logic [PW-1:0] rbin, level;

   always_comb begin
      rbin = '0;
      for (int i = 0; i < PW; i++) rbin[i] = ^(sync_rptr >> i);
      level = next_bin - rbin;
   end

   always_ff @(posedge write_clk or posedge write_reset) begin
      if (write_reset) write_almost_full <= 1'b0;
      else             write_almost_full <= (int'(level) >= almost_full_level);
   end
`else
   assign write_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_full.sv
// Bench for write_pointer_full: directed scenarios plus random traffic against a count-based FIFO model.
module tb_write_pointer_full;
   localparam int A  = 3;
   localparam int D  = 1 << A;
   localparam int D2 = 2 * D;
   localparam int AF = 6;
`ifdef FIFO_ALMOST_FULL_EN
   localparam bit AF_EN = 1'b1;
`else
   localparam bit AF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic [A:0]   rgray;
   logic [A-1:0] waddr;
   logic [A:0]   wgray;
   logic         wfull;
   logic         wafull;

   write_pointer_full #(.address_size(A), .almost_full_level(AF)) dut (
      .write_clk(clk), .write_reset(rst), .write_clk_en(en),
      .read_pointer_gray(rgray), .write_address(waddr),
      .write_pointer_gray(wgray), .write_full(wfull), .write_almost_full(wafull)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: counts of writes accepted and reads reported, plus the two-edge delay of the read count.
   int m_wp, m_rp, m_s1, m_s2;
   bit m_full, m_af;

   function automatic logic [A:0] to_gray(int v);
      logic [A:0] b;
      b = v[A:0];
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_wp = 0; m_s1 = 0; m_s2 = 0; m_full = 0; m_af = 0;
   endtask

   task automatic set_rp(int v);
      m_rp  = v & (D2 - 1);
      rgray = to_gray(m_rp);
   endtask

   task automatic cycle();
      int lvl;
      @(posedge clk);
      if (!rst) begin
         if (en && !m_full) m_wp = (m_wp + 1) & (D2 - 1);
         lvl    = (m_wp - m_s2) & (D2 - 1);
         m_full = (lvl == D);
         m_af   = (lvl >= AF);
         m_s2   = m_s1;
         m_s1   = m_rp;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; set_rp(0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; set_rp(0);
      model_reset();
      #1;
      n_checks++;
      if ({waddr, wgray, wfull, wafull} !== '0) begin
         n_fail++;
         $display("FAIL reset_async: got addr=%0d gray=%b full=%b af=%b, want all 0", waddr, wgray, wfull, wafull);
      end
      repeat (3) cycle();
      n_checks++;
      if ({waddr, wgray, wfull, wafull} !== '0) begin
         n_fail++;
         $display("FAIL reset_hold_en: got addr=%0d gray=%b full=%b af=%b, want all 0", waddr, wgray, wfull, wafull);
      end
      rst = 1'b0;
      cycle();
      n_checks++;
      if (waddr !== 3'd1 || wgray !== 4'b0001) begin
         n_fail++;
         $display("FAIL first_write: got addr=%0d gray=%b, want addr=1 gray=0001", waddr, wgray);
      end
      en = 1'b0;
   endtask

   task automatic test_fill();
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= D; i++) begin
         cycle();
         n_checks++;
         if (waddr !== A'(i % D) || wgray !== to_gray(i) || wfull !== (i == D)) begin
            n_fail++;
            $display("FAIL fill_%0d: got addr=%0d gray=%b full=%b, want addr=%0d gray=%b full=%0d",
                     i, waddr, wgray, wfull, i % D, to_gray(i), (i == D));
         end
      end
      n_checks++;
      if (wgray !== 4'b1100 || wfull !== 1'b1) begin
         n_fail++;
         $display("FAIL fill_final: got gray=%b full=%b, want gray=1100 full=1", wgray, wfull);
      end
   endtask

   task automatic test_full_hold();
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if (waddr !== 3'd0 || wgray !== 4'b1100 || wfull !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold_%0d: got addr=%0d gray=%b full=%b, want addr=0 gray=1100 full=1",
                     i, waddr, wgray, wfull);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_release();
      set_rp(1);
      for (int i = 1; i <= 3; i++) begin
         cycle();
         n_checks++;
         if (wfull !== (i < 3)) begin
            n_fail++;
            $display("FAIL release_edge_%0d: got full=%b, want %0d", i, wfull, (i < 3));
         end
      end
      en = 1'b1;
      cycle();
      en = 1'b0;
      n_checks++;
      if (wfull !== 1'b1 || waddr !== 3'd1 || wgray !== 4'b1101) begin
         n_fail++;
         $display("FAIL refill: got full=%b addr=%0d gray=%b, want full=1 addr=1 gray=1101", wfull, waddr, wgray);
      end
   endtask

   task automatic test_interleave();
      do_reset();
      for (int i = 0; i < D2; i++) begin
         en = 1'b1;
         cycle();
         en = 1'b0;
         set_rp(m_rp + 1);
         cycle();
         n_checks++;
         if (wfull !== 1'b0 || wgray !== to_gray(m_wp)) begin
            n_fail++;
            $display("FAIL interleave_%0d: got full=%b gray=%b, want full=0 gray=%b", i, wfull, wgray, to_gray(m_wp));
         end
      end
      repeat (3) cycle();
      n_checks++;
      if (wgray !== 4'b0000 || wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL interleave_wrap: got gray=%b full=%b, want gray=0000 full=0", wgray, wfull);
      end
   endtask

   task automatic test_almost_full();
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= AF; i++) begin
         cycle();
         if (i >= AF - 1) begin
            n_checks++;
            if (wafull !== (AF_EN && i >= AF)) begin
               n_fail++;
               $display("FAIL almost_full_%0d: got af=%b, want %0d", i, wafull, (AF_EN && i >= AF));
            end
         end
      end
      en = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         // Alternate producer-heavy and consumer-heavy phases so both full and near-empty are visited.
         en = ($urandom_range(0, 3) < ((i / 60) % 2 ? 1 : 3));
         if (((m_wp - m_rp) & (D2 - 1)) != 0 && $urandom_range(0, 3) < ((i / 60) % 2 ? 3 : 1))
            set_rp(m_rp + 1);
         cycle();
         n_checks++;
         if (waddr !== m_wp[A-1:0] || wgray !== to_gray(m_wp) || wfull !== m_full || wafull !== (AF_EN & m_af)) begin
            n_fail++;
            $display("FAIL random_%0d: got addr=%0d gray=%b full=%b af=%b, want addr=%0d gray=%b full=%b af=%b",
                     i, waddr, wgray, wfull, wafull, m_wp[A-1:0], to_gray(m_wp), m_full, AF_EN & m_af);
         end
      end
   endtask

   task automatic test_reset_midstream();
      en = 1'b1;
      repeat (5) cycle();
      #2;
      rst = 1'b1;
      set_rp(0);
      model_reset();
      #1;
      n_checks++;
      if ({waddr, wgray, wfull, wafull} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got addr=%0d gray=%b full=%b af=%b, want all 0", waddr, wgray, wfull, wafull);
      end
      cycle();
      rst = 1'b0;
      cycle();
      en = 1'b0;
      n_checks++;
      if (waddr !== 3'd1 || wgray !== 4'b0001 || wfull !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_first: got addr=%0d gray=%b full=%b, want addr=1 gray=0001 full=0",
                  waddr, wgray, wfull);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_hold();
      test_release();
      test_interleave();
      test_almost_full();
      test_random();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
